// File: rtl/uart_byte_tx_if.sv
// uart_byte_tx_if: request/status bundle between a byte producer and the UART
// transmitter. The producer drives tx_start/tx_data; the transmitter returns the
// serial line and its busy/done status.
interface uart_byte_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       txd;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_start,
    output tx_data,
    input  txd,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output txd,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 UART transmitter, one byte per request, LSB first.
// Bit time is BAUD_DIV = CLK_FREQ / BAUD clk cycles, from an internal divider.
// Build option UART_TX_PARITY_EN: inserts an even-parity bit after the data
// bits (8E1 framing). Left undefined, frames are 8N1 and no parity logic exists.
// All outputs come straight from flops, so txd is glitch-free.
module uart_byte_tx #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input logic           clk,
  input logic           rst,
  uart_byte_tx_if.slave tx_if
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
  localparam int unsigned CntW     = (BAUD_DIV >= 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(BAUD_DIV - 1);

  // A divider below 2 cannot form distinct bit periods.
  if (BAUD_DIV < 2) begin : g_div_check
    $error("uart_byte_tx: BAUD_DIV = CLK_FREQ / BAUD must be at least 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e          r_state;
  logic [CntW-1:0] r_baud_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_txd;
  logic            r_busy;
  logic            r_done;
`ifdef UART_TX_PARITY_EN
  logic            r_parity;
`endif

  logic w_baud_tc;
  logic w_accept;

  // Last cycle of the current bit period.
  assign w_baud_tc = (r_baud_cnt == BaudLast);

  // A request is taken in idle, or at the very end of a stop bit so that a
  // held tx_start chains the next frame with no idle gap.
  assign w_accept = tx_if.tx_start &&
                    ((r_state == StIdle) || ((r_state == StStop) && w_baud_tc));

  // Frame sequencer: state, bit/baud counters, shifter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state    <= StStart;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= tx_if.tx_data;
      r_txd      <= 1'b0;
      r_busy     <= 1'b1;
      // Chained accept still reports completion of the previous frame.
      r_done     <= (r_state == StStop);
`ifdef UART_TX_PARITY_EN
      r_parity   <= ^tx_if.tx_data;
`endif
    end else begin
      r_done <= 1'b0;
      if (r_state != StIdle) begin
        r_baud_cnt <= w_baud_tc ? '0 : r_baud_cnt + CntW'(1);
      end
      unique case (r_state)
        StIdle: begin
          r_txd  <= 1'b1;
          r_busy <= 1'b0;
        end
        StStart: begin
          if (w_baud_tc) begin
            r_state <= StData;
            r_txd   <= r_shift[0];
          end
        end
        StData: begin
          if (w_baud_tc) begin
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              r_state   <= StParity;
              r_txd     <= r_parity;
`else
              r_state   <= StStop;
              r_txd     <= 1'b1;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_txd     <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (w_baud_tc) begin
            r_state <= StStop;
            r_txd   <= 1'b1;
          end
        end
`endif
        StStop: begin
          if (w_baud_tc) begin
            r_state <= StIdle;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_if.txd     = r_txd;
  assign tx_if.tx_busy = r_busy;
  assign tx_if.tx_done = r_done;

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: scoreboard bench for uart_byte_tx at BAUD_DIV = 10.
// Stimulus pushes each accepted byte into exp_q; an independent line monitor
// decodes txd at mid-bit, checks framing and tx_done timing, and pops/compares.
module tb_uart_byte_tx;

  localparam int unsigned DIV  = 10;
  localparam int unsigned HALF = DIV / 2;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int unsigned FRAME = NBITS * DIV;

  logic clk = 1'b0;
  logic rst;

  uart_byte_tx_if bus ();

  uart_byte_tx #(
    .CLK_FREQ (1000000),
    .BAUD     (100000)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .tx_if (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, req, $time);
    end
  endtask

  // Even parity from the bit count of the byte.
  function automatic logic ref_parity(input logic [7:0] b);
    int unsigned ones = 0;
    for (int i = 0; i < 8; i++) ones += b[i];
    return logic'(ones % 2);
  endfunction

  // ---------------- line monitor ----------------
  int unsigned cyc      = 0;
  bit          mon_act  = 1'b0;
  int unsigned mon_t0   = 0;
  int unsigned last_end = 0;
  int unsigned last_gap = 0;
  logic [7:0]  mon_byte;
  logic        mon_par  = 1'b0;
  logic        last_par = 1'b0;

  always @(negedge clk) begin : monitor
    int unsigned k;
    logic [7:0] e;
    cyc++;
    k = cyc - mon_t0;
    check("done_only_at_frame_end",
          (bus.tx_done === 1'b1) && !(mon_act && (k == FRAME)), 1'b0);
    if (rst) begin
      mon_act = 1'b0;
    end else if (mon_act) begin
      if (k == HALF) check("start_bit", bus.txd, 1'b0);
      for (int i = 0; i < 8; i++) begin
        if (k == HALF + (i + 1) * DIV) mon_byte[i] = bus.txd;
      end
      if (k == HALF + 9 * DIV) mon_par = bus.txd;
      if (k == HALF + (NBITS - 1) * DIV) check("stop_bit", bus.txd, 1'b1);
      if (k == FRAME) begin
        check("done_at_frame_end", bus.tx_done, 1'b1);
        check("frame_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("decoded_byte", mon_byte, e);
`ifdef UART_TX_PARITY_EN
          check("parity_bit", mon_par, ref_parity(e));
`endif
        end
        last_par = mon_par;
        mon_act  = 1'b0;
        last_end = cyc;
      end
    end
    if (!rst && !mon_act && bus.txd === 1'b0) begin
      mon_act  = 1'b1;
      mon_t0   = cyc;
      last_gap = cyc - last_end;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    bus.tx_start = 1'b1;
    bus.tx_data  = d;
    exp_q.push_back(d);
    tick();
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'($urandom);
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      @(negedge clk);
      if (bus.tx_done === 1'b1) seen = 1'b1;
    end
    check({name, "_done_seen"}, seen, 1'b1);
  endtask

  task automatic idle_check(input int unsigned n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({name, "_txd"}, bus.txd, 1'b1);
      check({name, "_busy"}, bus.tx_busy, 1'b0);
      check({name, "_done"}, bus.tx_done, 1'b0);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, required self-termination");
    $fatal(1, "time limit");
  end

  initial begin : stim
    logic [7:0] b;
    rst          = 1'b1;
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;

    // Reset held, then idle line.
    repeat (5) tick();
    rst = 1'b0;
    idle_check(20, "reset_idle");

    // Single 0x55 frame with the busy window measured from the accept edge.
    send(8'h55);
    for (int i = 0; i <= FRAME; i++) begin
      @(negedge clk);
      check("busy_window", bus.tx_busy, (i < FRAME) ? 1'b1 : 1'b0);
      if (i == FRAME) check("done_cycle_55", bus.tx_done, 1'b1);
    end
    idle_check(3, "after_55");

    // Back-to-back with tx_start held: A3 then 0F, no idle gap.
    bus.tx_start = 1'b1;
    bus.tx_data  = 8'hA3;
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    tick();
    bus.tx_data = 8'h0F;
    wait_done("b2b_first");
    tick();
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'($urandom);
    wait_done("b2b_second");
    check("b2b_gap", last_gap, 0);
    idle_check(3, "after_b2b");

    // Requests while busy are dropped.
    send(8'h00);
    repeat (4) tick();
    bus.tx_start = 1'b1;
    bus.tx_data  = 8'hFF;
    tick();
    bus.tx_start = 1'b0;
    repeat (44) tick();
    bus.tx_start = 1'b1;
    tick();
    bus.tx_start = 1'b0;
    wait_done("ignore_busy");
    idle_check(30, "ignore_idle");

    // Reset in the middle of a frame (during a zero data bit).
    b = 8'($urandom) & 8'hFB;
    send(b);
    repeat (36) tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_txd", bus.txd, 1'b1);
    check("abort_busy", bus.tx_busy, 1'b0);
    idle_check(2 * FRAME, "abort_idle");
    send(8'($urandom));
    wait_done("post_abort");

`ifdef UART_TX_PARITY_EN
    send(8'h07);
    wait_done("par07");
    check("parity_07", last_par, 1'b1);
    send(8'h03);
    wait_done("par03");
    check("parity_03", last_par, 1'b0);
`endif

    // Random bytes with random idle gaps.
    repeat (8) begin
      repeat ($urandom_range(0, 15)) tick();
      send(8'($urandom));
      wait_done("rand");
    end

    idle_check(5, "final_idle");
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
